// File: rtl/cbus_port_manage.sv
// -----------------------------------------------------------------------------
// cbus_port_manage
//
// Multiplexes NUM_PORTS cbus requesters onto one downstream cbus port. Once a
// requester wins arbitration it owns the downstream port for its whole burst;
// the grant ends when the downstream side signals ready together with last, or
// early when the owner drops its valid. Between any two grants there is at
// least one IDLE cycle in which the arbitration happens.
//
// While granted, the owner's request is forwarded with kseg0/kseg1 addresses
// (addr[31:29] = 3'b100 / 3'b101) folded down to the physical range by
// clearing addr[31:29]. All other addresses pass through untouched.
//
// Configuration macro:
//   CBUS_RR_ARB_EN  defined   -> round-robin arbitration. The search starts at
//                                a pointer and wraps; the pointer moves to the
//                                port after the owner when a burst completes
//                                or is aborted.
//                   undefined -> fixed priority, lowest index wins; no pointer.
//
// Parameters:
//   NUM_PORTS  number of requesters (2..8)
//   IDX_W      width of grant_idx
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   ireqs      per-port requests (index 0 = lowest-numbered port)
//   iresps     per-port responses; only the owner sees the downstream response
//   oreq       merged downstream request (all-zero when idle)
//   oresp      downstream response
//   busy       high while a transaction is granted
//   grant_idx  index of the owner; only meaningful while busy
// -----------------------------------------------------------------------------

`ifndef CBUS_PORT_MANAGE_TYPES_SV
`define CBUS_PORT_MANAGE_TYPES_SV
typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  len;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
} cbus_resp_t;
`endif

module cbus_port_manage #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_PORTS-1:0]  ireqs,
    output cbus_resp_t [NUM_PORTS-1:0]  iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        busy,
    output logic       [IDX_W-1:0]      grant_idx
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;

    // Arbitration result, evaluated every cycle but only used in IDLE.
    logic             any_valid;
    logic [IDX_W-1:0] sel_idx;

    // Pulses in the BUSY cycle whose edge ends the burst (completion or abort).
    logic             burst_end;

    // Fold kseg0/kseg1 virtual addresses onto the physical range.
    function automatic cbus_req_t xlate(input cbus_req_t r);
        cbus_req_t t;
        t = r;
        if (r.addr[31:29] == 3'b100 || r.addr[31:29] == 3'b101) begin
            t.addr[31:29] = 3'b000;
        end
        return t;
    endfunction

`ifdef CBUS_RR_ARB_EN
    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_inc;
    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W-1:0] rr_idx;

    always_comb begin
        any_valid = 1'b0;
        sel_idx   = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (rr_sum >= (IDX_W + 1)'(NUM_PORTS)) begin
                rr_sum = rr_sum - (IDX_W + 1)'(NUM_PORTS);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            // First valid port found from the pointer onwards wins.
            if (!any_valid && ireqs[rr_idx].valid) begin
                any_valid = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        if (grant_q == IDX_W'(NUM_PORTS - 1)) begin
            grant_inc = '0;
        end else begin
            grant_inc = grant_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (burst_end) begin
            ptr_q <= grant_inc;
        end
    end
`else
    // -------------------------------------------------------------------------
    // Fixed-priority arbitration: scanning downwards lets the lowest index win.
    // -------------------------------------------------------------------------
    always_comb begin
        any_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (ireqs[i].valid) begin
                any_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // FSM: state and grant registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and outputs
    // -------------------------------------------------------------------------
    // Outputs are decoded from the state register, so an asynchronous reset
    // forces oreq/iresps to zero in the same cycle it is asserted.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        burst_end = 1'b0;
        busy      = 1'b0;
        oreq      = '0;
        iresps    = '0;

        case (state_q)
            StIdle: begin
                // Downstream ready/last are deliberately not looked at here.
                if (any_valid) begin
                    state_d = StBusy;
                    grant_d = sel_idx;
                end
            end

            StBusy: begin
                busy            = 1'b1;
                oreq            = xlate(ireqs[grant_q]);
                iresps[grant_q] = oresp;
                if (!ireqs[grant_q].valid) begin
                    // Owner withdrew before its last beat: abort the burst.
                    state_d   = StIdle;
                    burst_end = 1'b1;
                end else if (oresp.ready && oresp.last) begin
                    state_d   = StIdle;
                    burst_end = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_port_manage.sv
// -----------------------------------------------------------------------------
// tb_cbus_port_manage
//
// Directed bench for cbus_port_manage with NUM_PORTS = 3. Inputs are driven
// 1 time unit after the rising edge and outputs are checked 2 units after it.
// Expected values are hand-computed constants; arbitration expectations follow
// CBUS_RR_ARB_EN the same way the design does.
// -----------------------------------------------------------------------------

`ifndef CBUS_PORT_MANAGE_TYPES_SV
`define CBUS_PORT_MANAGE_TYPES_SV
typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  len;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
} cbus_resp_t;
`endif

module tb_cbus_port_manage;

    localparam int NP = 3;

    logic                clk = 1'b0;
    logic                reset;
    cbus_req_t  [NP-1:0] ireqs;
    cbus_resp_t [NP-1:0] iresps;
    cbus_req_t           oreq;
    cbus_resp_t          oresp;
    logic                busy;
    logic [1:0]          grant_idx;

    int n_checks = 0;
    int n_pass   = 0;

    cbus_port_manage #(
        .NUM_PORTS (NP),
        .IDX_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [7:0] len);
        ireqs[p].valid = v;
        ireqs[p].write = 1'b0;
        ireqs[p].addr  = a;
        ireqs[p].wdata = 32'hD000_0000 + 32'(p);
        ireqs[p].wstrb = 4'hF;
        ireqs[p].len   = len;
    endtask

    task automatic set_resp(input logic r, input logic l, input logic [31:0] d);
        oresp.ready = r;
        oresp.last  = l;
        oresp.rdata = d;
    endtask

    // Watchdog: every wait is a fixed number of cycles, this is a backstop.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] xl_in  [4] = '{32'h4000_0010, 32'hA000_0004, 32'hC000_0000, 32'h0000_0100};
    logic [31:0] xl_out [4] = '{32'h4000_0010, 32'h0000_0004, 32'hC000_0000, 32'h0000_0100};
`ifdef CBUS_RR_ARB_EN
    logic [1:0]  pair_grants [3] = '{2'd0, 2'd2, 2'd0};
    logic [1:0]  exp_after_abort = 2'd1;
`else
    logic [1:0]  pair_grants [3] = '{2'd0, 2'd0, 2'd0};
    logic [1:0]  exp_after_abort = 2'd0;
`endif

    cbus_req_t  ereq;
    cbus_resp_t eresp;

    initial begin
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        #2;
        // ---- reset state ----
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_idx, 2'd0);
        check("rst_oreq", oreq, '0);
        check("rst_iresps", iresps, '0);
        step();
        reset = 1'b0;
        step();

        // ---- port 1 alone, kseg1 address, 4 beats ----
        set_req(1, 1'b1, 32'hBFC0_0000, 8'd4);
        #1;
        check("p1_idle_oreq", oreq, '0);
        check("p1_idle_busy", busy, 1'b0);
        step();
        #1;
        check("p1_busy", busy, 1'b1);
        check("p1_grant", grant_idx, 2'd1);
        ereq      = ireqs[1];
        ereq.addr = 32'h1FC0_0000;
        check("p1_oreq", oreq, ereq);
        for (int b = 0; b < 4; b++) begin
            set_resp(1'b1, (b == 3), 32'h100 + 32'(b));
            #1;
            eresp.ready = 1'b1;
            eresp.last  = (b == 3);
            eresp.rdata = 32'h100 + 32'(b);
            check("p1_iresp1", iresps[1], eresp);
            check("p1_iresp0", iresps[0], '0);
            check("p1_iresp2", iresps[2], '0);
            if (b < 3) check("p1_hold", busy, 1'b1);
            step();
        end
        ireqs[1].valid = 1'b0;
        oresp          = '0;
        #1;
        check("p1_done_busy", busy, 1'b0);
        check("p1_done_oreq", oreq, '0);
        step();

        // ---- address translation table, port 0, single beat ----
        for (int t = 0; t < 4; t++) begin
            set_req(0, 1'b1, xl_in[t], 8'd1);
            step();
            #1;
            check("xl_busy", busy, 1'b1);
            check("xl_addr", oreq.addr, xl_out[t]);
            set_resp(1'b1, 1'b1, 32'h0);
            step();
            ireqs[0].valid = 1'b0;
            oresp          = '0;
            step();
        end

        // ---- ready/last while idle are ignored ----
        set_resp(1'b1, 1'b1, 32'hABC);
        #1;
        check("idle_resp_iresps", iresps, '0);
        check("idle_resp_busy", busy, 1'b0);
        step();
        #1;
        check("idle_resp_stay", busy, 1'b0);
        oresp = '0;

        // ---- port 2 holds grant while port 0 requests mid-burst ----
        set_req(2, 1'b1, 32'h8000_1000, 8'd2);
        step();
        #1;
        check("p2_grant", grant_idx, 2'd2);
        check("p2_addr", oreq.addr, 32'h0000_1000);
        set_req(0, 1'b1, 32'h4000_0000, 8'd1);
        set_resp(1'b1, 1'b0, 32'h55);
        step();
        #1;
        check("p2_hold_busy", busy, 1'b1);
        check("p2_hold_grant", grant_idx, 2'd2);
        check("p2_iresp0", iresps[0], '0);
        set_resp(1'b1, 1'b1, 32'h66);
        step();
        ireqs[2].valid = 1'b0;
        oresp          = '0;
        #1;
        check("p2_gap", busy, 1'b0);
        step();
        #1;
        check("p2_next_grant", grant_idx, 2'd0);
        check("p2_next_busy", busy, 1'b1);
        set_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs[0].valid = 1'b0;
        oresp          = '0;
        step();

        // ---- ports 0 and 2 together from a fresh pointer ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 1'b1, 32'h0000_0200, 8'd1);
        set_req(2, 1'b1, 32'h0000_0300, 8'd1);
        for (int g = 0; g < 3; g++) begin
            step();
            #1;
            check("pair_busy", busy, 1'b1);
            check("pair_grant", grant_idx, pair_grants[g]);
            set_resp(1'b1, 1'b1, 32'h0);
            step();
            oresp = '0;
            #1;
            check("pair_gap", busy, 1'b0);
        end
        ireqs = '0;
        step();

        // ---- reset on beat 2 of a 4-beat burst ----
        set_req(1, 1'b1, 32'h9000_0040, 8'd4);
        step();
        #1;
        check("rb_grant", grant_idx, 2'd1);
        set_resp(1'b1, 1'b0, 32'h1);
        step();
        set_resp(1'b1, 1'b0, 32'h2);
        reset = 1'b1;
        #1;
        check("rb_busy", busy, 1'b0);
        check("rb_oreq_valid", oreq.valid, 1'b0);
        check("rb_iresps", iresps, '0);
        step();
        reset = 1'b0;
        oresp = '0;
        #1;
        check("rb_rel_idle", busy, 1'b0);
        step();
        #1;
        check("rb_regrant_busy", busy, 1'b1);
        check("rb_regrant_idx", grant_idx, 2'd1);
        set_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs[1].valid = 1'b0;
        oresp          = '0;
        step();

        // ---- owner drops valid at beat 1 ----
        set_req(0, 1'b1, 32'h0000_0400, 8'd4);
        step();
        #1;
        check("ab_grant", grant_idx, 2'd0);
        set_resp(1'b1, 1'b0, 32'h7);
        step();
        ireqs[0].valid = 1'b0;
        step();
        #1;
        check("ab_idle", busy, 1'b0);
        check("ab_iresps", iresps, '0);
        check("ab_oreq", oreq, '0);
        oresp = '0;
        set_req(0, 1'b1, 32'h0000_0500, 8'd1);
        set_req(1, 1'b1, 32'h0000_0600, 8'd1);
        step();
        #1;
        check("ab_next_grant", grant_idx, exp_after_abort);
        set_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs = '0;
        oresp = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
